// File: rtl/pkt_gen_pkg.sv
// Shared constants and helpers for the packet-generator datapath.
// Imported by the task engine and the task dispatcher.
package pkt_gen_pkg;

    localparam int PKT_SIZE_WIDTH     = 16;
    localparam int DISPATCH_CNT_WIDTH = 32;

    typedef logic [PKT_SIZE_WIDTH-1:0] pkt_size_t;

    // Index width for n items; a single item still needs one bit.
    function automatic int clog2_min1(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/pkt_gen_rr_arbiter.sv
// Combinational round-robin search: first requester at or after i_ptr,
// wrapping modulo LANE_CNT.
module pkt_gen_rr_arbiter
    import pkt_gen_pkg::*;
#(
    parameter int LANE_CNT       = 4,
    parameter int LANE_CNT_WIDTH = clog2_min1(LANE_CNT)
) (
    input  logic [LANE_CNT-1:0]       i_req,
    input  logic [LANE_CNT_WIDTH-1:0] i_ptr,
    output logic [LANE_CNT-1:0]       o_gnt,
    output logic [LANE_CNT_WIDTH-1:0] o_gnt_idx,
    output logic                      o_gnt_vld
);

    logic [LANE_CNT-1:0]       w_rot;
    logic [LANE_CNT_WIDTH-1:0] w_first;
    logic [LANE_CNT_WIDTH:0]   w_sum;

    // Rotate so that bit 0 is the lane at i_ptr, then pick the lowest set bit.
    assign w_rot = LANE_CNT'({i_req, i_req} >> i_ptr);

    always_comb begin
        w_first   = '0;
        o_gnt_vld = 1'b0;
        for (int k = LANE_CNT - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_first   = LANE_CNT_WIDTH'(k);
                o_gnt_vld = 1'b1;
            end
        end
    end

    always_comb begin
        w_sum = {1'b0, i_ptr} + {1'b0, w_first};
        if (w_sum >= (LANE_CNT_WIDTH + 1)'(LANE_CNT)) begin
            w_sum = w_sum - (LANE_CNT_WIDTH + 1)'(LANE_CNT);
        end
        o_gnt_idx = w_sum[LANE_CNT_WIDTH-1:0];
        o_gnt     = o_gnt_vld ? (LANE_CNT'(1) << o_gnt_idx) : '0;
    end

endmodule

// File: rtl/pkt_gen_task_dispatcher.sv
// Task FIFO feeding LANE_CNT generator lanes round-robin, one grant per
// clock, with per-lane holding registers and a dispatch counter.
module pkt_gen_task_dispatcher
    import pkt_gen_pkg::*;
#(
    parameter int FLOW_CNT       = 16,
    parameter int FLOW_CNT_WIDTH = clog2_min1(FLOW_CNT),
    parameter int LANE_CNT       = 4,
    parameter int LANE_CNT_WIDTH = clog2_min1(LANE_CNT),
    parameter int FIFO_DEPTH     = 8
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic [FLOW_CNT_WIDTH-1:0]          task_flow_num_i,
    input  logic [PKT_SIZE_WIDTH-1:0]          task_pkt_size_i,
    input  logic                               task_valid_i,
    output logic                               task_ready_o,
    input  logic [LANE_CNT-1:0]                lane_en_i,
    input  logic                               flush_i,
    output logic [LANE_CNT*FLOW_CNT_WIDTH-1:0] lane_flow_num_o,
    output logic [LANE_CNT*PKT_SIZE_WIDTH-1:0] lane_pkt_size_o,
    output logic [LANE_CNT-1:0]                lane_valid_o,
    input  logic [LANE_CNT-1:0]                lane_ready_i,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_used_o,
    output logic [DISPATCH_CNT_WIDTH-1:0]      dispatch_cnt_o
);

    localparam int PTR_W  = clog2_min1(FIFO_DEPTH);
    localparam int USED_W = $clog2(FIFO_DEPTH + 1);

    logic [FLOW_CNT_WIDTH-1:0] r_mem_flow [FIFO_DEPTH];
    logic [PKT_SIZE_WIDTH-1:0] r_mem_size [FIFO_DEPTH];
    logic [PTR_W-1:0]          r_wr_ptr;
    logic [PTR_W-1:0]          r_rd_ptr;
    logic [USED_W-1:0]         r_used;
    logic [LANE_CNT_WIDTH-1:0] r_rr_ptr;

    logic [LANE_CNT-1:0][FLOW_CNT_WIDTH-1:0] r_lane_flow;
    logic [LANE_CNT-1:0][PKT_SIZE_WIDTH-1:0] r_lane_size;
    logic [LANE_CNT-1:0]                     r_lane_vld;
    logic [DISPATCH_CNT_WIDTH-1:0]           r_disp_cnt;

    logic                      w_full;
    logic                      w_empty;
    logic                      w_push;
    logic                      w_pop;
    logic [LANE_CNT-1:0]       w_avail;
    logic [LANE_CNT-1:0]       w_gnt;
    logic [LANE_CNT-1:0]       w_gnt_sel;
    logic [LANE_CNT_WIDTH-1:0] w_gnt_idx;
    logic                      w_gnt_vld;

    assign w_full       = (r_used == USED_W'(FIFO_DEPTH));
    assign w_empty      = (r_used == '0);
    assign task_ready_o = !rst_i && !w_full && !flush_i;
    assign w_push       = task_valid_i && task_ready_o;
    assign w_avail      = lane_en_i & (~r_lane_vld | lane_ready_i);

    pkt_gen_rr_arbiter #(
        .LANE_CNT       (LANE_CNT),
        .LANE_CNT_WIDTH (LANE_CNT_WIDTH)
    ) u_arb (
        .i_req     (w_avail),
        .i_ptr     (r_rr_ptr),
        .o_gnt     (w_gnt),
        .o_gnt_idx (w_gnt_idx),
        .o_gnt_vld (w_gnt_vld)
    );

    // Only the head already in storage can go out, so a push never bypasses.
    assign w_pop     = w_gnt_vld && !w_empty && !flush_i;
    assign w_gnt_sel = w_gnt & {LANE_CNT{w_pop}};

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem_flow[r_wr_ptr] <= task_flow_num_i;
            r_mem_size[r_wr_ptr] <= task_pkt_size_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_used   <= '0;
        end else if (flush_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_used   <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            if (w_push && !w_pop) begin
                r_used <= r_used + USED_W'(1);
            end else if (!w_push && w_pop) begin
                r_used <= r_used - USED_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_lane_vld  <= '0;
            r_lane_flow <= '0;
            r_lane_size <= '0;
        end else begin
            for (int i = 0; i < LANE_CNT; i++) begin
                if (w_gnt_sel[i]) begin
                    r_lane_vld[i]  <= 1'b1;
                    r_lane_flow[i] <= r_mem_flow[r_rd_ptr];
                    r_lane_size[i] <= r_mem_size[r_rd_ptr];
                end else if (lane_ready_i[i]) begin
                    r_lane_vld[i]  <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_rr_ptr   <= '0;
            r_disp_cnt <= '0;
        end else if (w_pop) begin
            r_rr_ptr   <= (w_gnt_idx == LANE_CNT_WIDTH'(LANE_CNT - 1)) ?
                          '0 : w_gnt_idx + LANE_CNT_WIDTH'(1);
            r_disp_cnt <= r_disp_cnt + DISPATCH_CNT_WIDTH'(1);
        end
    end

    assign lane_flow_num_o = r_lane_flow;
    assign lane_pkt_size_o = r_lane_size;
    assign lane_valid_o    = r_lane_vld;
    assign fifo_used_o     = r_used;
    assign dispatch_cnt_o  = r_disp_cnt;

endmodule

// File: tb/tb_pkt_gen_task_dispatcher.sv
// Bench for pkt_gen_task_dispatcher: vector table, directed corner
// sequences and a random run against a queue-based reference model.
module tb_pkt_gen_task_dispatcher;

    localparam int LN    = 4;
    localparam int FW    = 4;
    localparam int SW    = 16;
    localparam int DEPTH = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [FW-1:0] t_flow;
    logic [SW-1:0] t_size;
    logic          t_valid;
    logic          task_ready;
    logic [LN-1:0] l_en;
    logic          flush;
    logic [LN*FW-1:0] l_flow;
    logic [LN*SW-1:0] l_size;
    logic [LN-1:0] l_valid;
    logic [LN-1:0] l_ready;
    logic [3:0]    used;
    logic [31:0]   cnt;

    always #5 clk = ~clk;

    pkt_gen_task_dispatcher #(
        .FLOW_CNT   (16),
        .LANE_CNT   (LN),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .task_flow_num_i (t_flow),
        .task_pkt_size_i (t_size),
        .task_valid_i    (t_valid),
        .task_ready_o    (task_ready),
        .lane_en_i       (l_en),
        .flush_i         (flush),
        .lane_flow_num_o (l_flow),
        .lane_pkt_size_o (l_size),
        .lane_valid_o    (l_valid),
        .lane_ready_i    (l_ready),
        .fifo_used_o     (used),
        .dispatch_cnt_o  (cnt)
    );

    int n_vec = 0;
    int n_err = 0;
    bit s_rdy;

    typedef struct packed {
        logic [FW-1:0] f;
        logic [SW-1:0] s;
    } tsk_t;

    tsk_t          q[$];
    bit            m_lv[LN];
    logic [FW-1:0] m_lf[LN];
    logic [SW-1:0] m_ls[LN];
    int            m_rr;
    logic [31:0]   m_cnt;

    typedef struct {
        bit            v;
        logic [FW-1:0] f;
        bit            rdy;
        logic [LN-1:0] lv;
        int            used;
        int            cnt;
        int            lane;
        logic [FW-1:0] ef;
    } vec_t;

    vec_t tbl[10];

    function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endfunction

    function automatic void m_reset();
        q.delete();
        for (int l = 0; l < LN; l++) begin
            m_lv[l] = 1'b0;
            m_lf[l] = '0;
            m_ls[l] = '0;
        end
        m_rr  = 0;
        m_cnt = '0;
    endfunction

    function automatic bit m_ready();
        return !rst && (q.size() < DEPTH) && !flush;
    endfunction

    // One clock of the dispatcher described as queue operations.
    function automatic void m_edge();
        bit   push;
        int   g;
        tsk_t t;
        push = t_valid && m_ready();
        g = -1;
        if (q.size() > 0 && !flush) begin
            for (int k = 0; k < LN; k++) begin
                int l;
                l = (m_rr + k) % LN;
                if (g < 0 && l_en[l] && (!m_lv[l] || l_ready[l])) g = l;
            end
        end
        for (int l = 0; l < LN; l++) begin
            if (m_lv[l] && l_ready[l]) m_lv[l] = 1'b0;
        end
        if (g >= 0) begin
            t = q.pop_front();
            m_lv[g] = 1'b1;
            m_lf[g] = t.f;
            m_ls[g] = t.s;
            m_rr    = (g + 1) % LN;
            m_cnt   = m_cnt + 32'd1;
        end
        if (flush) q.delete();
        if (push) q.push_back({t_flow, t_size});
    endfunction

    task automatic check_outputs();
        logic [LN-1:0]    ev;
        logic [LN*FW-1:0] ef;
        logic [LN*SW-1:0] es;
        for (int l = 0; l < LN; l++) begin
            ev[l]           = m_lv[l];
            ef[l*FW +: FW]  = m_lf[l];
            es[l*SW +: SW]  = m_ls[l];
        end
        chk("lane_valid", l_valid, ev);
        chk("lane_flow", l_flow, ef);
        chk("lane_size", l_size, es);
        chk("fifo_used", used, q.size());
        chk("dispatch_cnt", cnt, m_cnt);
    endtask

    task automatic cycle();
        @(negedge clk);
        s_rdy = task_ready;
        chk("task_ready", task_ready, m_ready());
        @(posedge clk);
        if (!rst) m_edge();
        #1;
        check_outputs();
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        t_valid = 1'b0;
        flush   = 1'b0;
        t_flow  = '0;
        t_size  = '0;
        m_reset();
        repeat (2) cycle();
        rst = 1'b0;
    endtask

    initial begin
        int glist[$];
        logic [LN-1:0] seen;

        tbl[0] = '{1'b1, 4'd0, 1'b1, 4'b0000, 1, 0, -1, 4'd0};
        tbl[1] = '{1'b1, 4'd1, 1'b1, 4'b0001, 1, 1,  0, 4'd0};
        tbl[2] = '{1'b1, 4'd2, 1'b1, 4'b0010, 1, 2,  1, 4'd1};
        tbl[3] = '{1'b1, 4'd3, 1'b1, 4'b0100, 1, 3,  2, 4'd2};
        tbl[4] = '{1'b1, 4'd4, 1'b1, 4'b1000, 1, 4,  3, 4'd3};
        tbl[5] = '{1'b1, 4'd5, 1'b1, 4'b0001, 1, 5,  0, 4'd4};
        tbl[6] = '{1'b1, 4'd6, 1'b1, 4'b0010, 1, 6,  1, 4'd5};
        tbl[7] = '{1'b1, 4'd7, 1'b1, 4'b0100, 1, 7,  2, 4'd6};
        tbl[8] = '{1'b0, 4'd0, 1'b1, 4'b1000, 0, 8,  3, 4'd7};
        tbl[9] = '{1'b0, 4'd0, 1'b1, 4'b0000, 0, 8, -1, 4'd0};

        // Back-to-back burst, all lanes draining.
        l_en    = '1;
        l_ready = '1;
        do_reset();
        t_size = 16'd64;
        for (int i = 0; i < 10; i++) begin
            t_valid = tbl[i].v;
            t_flow  = tbl[i].f;
            cycle();
            chk($sformatf("tbl%0d_ready", i), s_rdy, tbl[i].rdy);
            chk($sformatf("tbl%0d_valid", i), l_valid, tbl[i].lv);
            chk($sformatf("tbl%0d_used", i), used, tbl[i].used);
            chk($sformatf("tbl%0d_cnt", i), cnt, tbl[i].cnt);
            if (tbl[i].lane >= 0) begin
                chk($sformatf("tbl%0d_flow", i),
                    l_flow[tbl[i].lane*FW +: FW], tbl[i].ef);
            end
        end

        // Stalled lanes: fill to full, then drain through lane 2 only.
        l_ready = '0;
        do_reset();
        t_size = 16'd200;
        for (int i = 0; i < 12; i++) begin
            t_valid = 1'b1;
            t_flow  = FW'(i);
            cycle();
        end
        t_flow = 4'd12;
        cycle();
        chk("full_ready", s_rdy, 1'b0);
        chk("full_used", used, 8);
        chk("full_held", l_valid, 4'b1111);
        t_valid = 1'b0;
        l_ready = 4'b0100;
        for (int j = 0; j < 8; j++) begin
            cycle();
            chk($sformatf("lane2_flow%0d", j), l_flow[2*FW +: FW], 4 + j);
            chk($sformatf("lane2_others%0d", j), l_valid, 4'b1111);
        end
        cycle();
        chk("lane2_drained", l_valid, 4'b1011);

        // Sparse enable mask.
        l_en    = 4'b0101;
        l_ready = '1;
        do_reset();
        seen = '0;
        for (int i = 0; i < 9; i++) begin
            t_valid = (i < 6);
            t_flow  = FW'(i);
            cycle();
            seen = seen | l_valid;
            for (int l = 0; l < LN; l++) begin
                if (l_valid[l]) glist.push_back(l);
            end
        end
        chk("sparse_count", glist.size(), 6);
        for (int i = 0; i < glist.size() && i < 6; i++) begin
            chk($sformatf("sparse_order%0d", i), glist[i], (i % 2) * 2);
        end
        chk("sparse_never", {seen[3], seen[1]}, 2'b00);

        // Lane 1 holds a task while its ready stays low.
        l_en    = '1;
        l_ready = 4'b1101;
        do_reset();
        t_valid = 1'b1;
        t_flow  = 4'd3;
        t_size  = 16'd100;
        cycle();
        t_flow = 4'd5;
        t_size = 16'd1500;
        cycle();
        t_valid = 1'b0;
        cycle();
        for (int i = 0; i < 10; i++) begin
            cycle();
            chk("hold_valid", l_valid[1], 1'b1);
            chk("hold_flow", l_flow[1*FW +: FW], 4'd5);
            chk("hold_size", l_size[1*SW +: SW], 16'd1500);
        end
        l_ready[1] = 1'b1;
        cycle();
        chk("hold_release", l_valid[1], 1'b0);

        // Flush with tasks queued and lanes held.
        l_ready = '0;
        do_reset();
        t_size = 16'd77;
        for (int i = 0; i < 9; i++) begin
            t_valid = 1'b1;
            t_flow  = FW'(i);
            cycle();
        end
        chk("pre_flush_used", used, 5);
        flush  = 1'b1;
        t_flow = 4'd15;
        cycle();
        chk("flush_ready", s_rdy, 1'b0);
        chk("flush_used", used, 0);
        chk("flush_held", l_valid, 4'b1111);
        chk("flush_cnt", cnt, 4);
        flush   = 1'b0;
        t_valid = 1'b0;
        cycle();
        chk("post_flush_used", used, 0);
        chk("post_flush_held", l_valid, 4'b1111);

        // Asynchronous reset mid-burst, rr pointer left at lane 3.
        l_en    = 4'b0111;
        l_ready = '0;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            t_valid = 1'b1;
            t_flow  = FW'(i);
            cycle();
        end
        chk("pre_rst_valid", l_valid, 4'b0111);
        #2 rst = 1'b1;
        #1;
        chk("async_valid", l_valid, 4'b0000);
        chk("async_used", used, 0);
        chk("async_cnt", cnt, 0);
        chk("async_ready", task_ready, 1'b0);
        m_reset();
        t_valid = 1'b0;
        repeat (2) cycle();
        rst     = 1'b0;
        l_en    = '1;
        l_ready = '1;
        t_valid = 1'b1;
        t_flow  = 4'd9;
        cycle();
        t_valid = 1'b0;
        cycle();
        chk("post_rst_lane0", l_valid, 4'b0001);
        chk("post_rst_flow", l_flow[0 +: FW], 4'd9);

        // Random traffic against the model.
        l_en    = '1;
        l_ready = '1;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            if (c % 80 == 0) l_en = LN'($urandom_range(0, 15));
            t_valid = ($urandom_range(0, 3) != 0);
            t_flow  = FW'($urandom);
            t_size  = SW'($urandom);
            l_ready = LN'($urandom);
            flush   = ($urandom_range(0, 39) == 0);
            cycle();
        end
        flush   = 1'b0;
        t_valid = 1'b0;
        l_en    = '1;
        l_ready = '1;
        repeat (12) cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
